// File: rtl/sand_brush_painter.sv
// Brush stamper: writes a BRUSH_SIZE x BRUSH_SIZE square of sand or empty cells
// into VRAM at the cursor, one cell per cycle, only while the draw window is open.
module sand_brush_painter #(
    parameter int unsigned ACTIVE_COLUMNS = 640,
    parameter int unsigned ACTIVE_ROWS    = 480,
    parameter int unsigned ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int unsigned DATA_WIDTH     = 1,
    parameter int unsigned BRUSH_SIZE     = 4,
    parameter int unsigned X_WIDTH        = $clog2(ACTIVE_COLUMNS),
    parameter int unsigned Y_WIDTH        = $clog2(ACTIVE_ROWS)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  draw_en_i,
    input  logic                  button_i,
    input  logic                  erase_i,
    input  logic [X_WIDTH-1:0]    cursor_x_i,
    input  logic [Y_WIDTH-1:0]    cursor_y_i,
    output logic [ADDR_WIDTH-1:0] wr_address_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  wr_en_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned CNT_WIDTH = (BRUSH_SIZE > 1) ? $clog2(BRUSH_SIZE) : 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST   = CNT_WIDTH'(BRUSH_SIZE - 1);
    localparam logic [X_WIDTH:0]      X_LIMIT    = (X_WIDTH + 1)'(ACTIVE_COLUMNS);
    localparam logic [Y_WIDTH:0]      Y_LIMIT    = (Y_WIDTH + 1)'(ACTIVE_ROWS);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(ACTIVE_COLUMNS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PAINT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]            state_q,    state_d;
    logic [X_WIDTH-1:0]    x0_q,       x0_d;
    logic [Y_WIDTH-1:0]    y0_q,       y0_d;
    logic [CNT_WIDTH-1:0]  dx_q,       dx_d;
    logic [CNT_WIDTH-1:0]  dy_q,       dy_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] data_q,     data_d;
    logic                  wr_en_q,    wr_en_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;

    logic [CNT_WIDTH-1:0]  next_dx;
    logic [CNT_WIDTH-1:0]  next_dy;
    logic [ADDR_WIDTH-1:0] next_base;
    logic [X_WIDTH:0]      x_sum;
    logic [Y_WIDTH:0]      y_sum;
    logic                  cursor_ok;

    // Output registers always describe the cell being written in the current cycle,
    // so each edge precomputes the address and clip flag of the following cell.
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_en_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        next_dx   = dx_q + 1'b1;
        next_dy   = dy_q;
        next_base = row_base_q;
        if (dx_q == CNT_LAST) begin
            next_dx   = '0;
            next_dy   = dy_q + 1'b1;
            next_base = row_base_q + ROW_STRIDE;
        end
        x_sum     = {1'b0, x0_q} + (X_WIDTH + 1)'(next_dx);
        y_sum     = {1'b0, y0_q} + (Y_WIDTH + 1)'(next_dy);
        cursor_ok = ({1'b0, cursor_x_i} < X_LIMIT) && ({1'b0, cursor_y_i} < Y_LIMIT);

        case (state_q)
            ST_IDLE: begin
                if (draw_en_i && button_i && cursor_ok) begin
                    state_d    = ST_PAINT;
                    x0_d       = cursor_x_i;
                    y0_d       = cursor_y_i;
                    data_d     = erase_i ? '0 : '1;
                    dx_d       = '0;
                    dy_d       = '0;
                    row_base_d = ADDR_WIDTH'(cursor_y_i) * ROW_STRIDE;
                    addr_d     = row_base_d + ADDR_WIDTH'(cursor_x_i);
                    wr_en_d    = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_PAINT: begin
                if (!draw_en_i) begin
                    state_d = ST_IDLE;
                end else if (dx_q == CNT_LAST && dy_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    dx_d       = next_dx;
                    dy_d       = next_dy;
                    row_base_d = next_base;
                    addr_d     = next_base + ADDR_WIDTH'(x_sum);
                    wr_en_d    = (x_sum < X_LIMIT) && (y_sum < Y_LIMIT);
                    busy_d     = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Closing the draw window must kill the strobe in the same cycle.
    assign wr_en_o      = wr_en_q & draw_en_i;
    assign wr_address_o = addr_q;
    assign wr_data_o    = data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_sand_brush_painter.sv
// Bench for sand_brush_painter: directed and random strokes checked against a
// per-cell model of the brush footprint, clipping, abort and reset behaviour.
module tb_sand_brush_painter;

    localparam int COLS  = 640;
    localparam int ROWS  = 480;
    localparam int BRUSH = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        draw_en_i;
    logic        button_i;
    logic        erase_i;
    logic [9:0]  cursor_x_i;
    logic [8:0]  cursor_y_i;
    logic [18:0] wr_address_o;
    logic [0:0]  wr_data_o;
    logic        wr_en_o;
    logic        busy_o;
    logic        done_o;

    int n_checks = 0;
    int n_errors = 0;

    sand_brush_painter dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .draw_en_i    (draw_en_i),
        .button_i     (button_i),
        .erase_i      (erase_i),
        .cursor_x_i   (cursor_x_i),
        .cursor_y_i   (cursor_y_i),
        .wr_address_o (wr_address_o),
        .wr_data_o    (wr_data_o),
        .wr_en_o      (wr_en_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Caller leaves the request on the inputs in an IDLE cycle; the next edge accepts it.
    task automatic run_stroke(input int cx, input int cy, input bit er,
                              input bit keep_button, input int abort_at);
        int x, y;
        bit en;
        @(posedge clk_i); #1;
        if (!keep_button) begin
            button_i   = 1'b0;
            cursor_x_i = 10'($urandom);
            cursor_y_i = 9'($urandom);
            erase_i    = 1'($urandom);
        end
        for (int i = 0; i < BRUSH * BRUSH; i++) begin
            x  = cx + i % BRUSH;
            y  = cy + i / BRUSH;
            en = (x < COLS) && (y < ROWS);
            if (i == abort_at) begin
                draw_en_i = 1'b0;
                en = 1'b0;
            end
            @(negedge clk_i);
            check("busy_paint", 32'(busy_o), 32'd1);
            check("wr_en", 32'(wr_en_o), 32'(en));
            if (en) begin
                check("wr_addr", 32'(wr_address_o), 32'(y * COLS + x));
                check("wr_data", 32'(wr_data_o), er ? 32'd0 : 32'd1);
            end
            if (i == abort_at) begin
                @(posedge clk_i); #1;
                @(negedge clk_i);
                check("abort_busy", 32'(busy_o), 32'd0);
                check("abort_done", 32'(done_o), 32'd0);
                check("abort_wr_en", 32'(wr_en_o), 32'd0);
                return;
            end
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        check("done_pulse", 32'(done_o), 32'd1);
        check("done_busy", 32'(busy_o), 32'd0);
        check("done_wr_en", 32'(wr_en_o), 32'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("post_done", 32'(done_o), 32'd0);
        check("post_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic request(input int cx, input int cy, input bit er);
        draw_en_i  = 1'b1;
        button_i   = 1'b1;
        erase_i    = er;
        cursor_x_i = 10'(cx);
        cursor_y_i = 9'(cy);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_addr"}, 32'(wr_address_o), 32'd0);
        check({tag, "_data"}, 32'(wr_data_o), 32'd0);
    endtask

    initial begin
        int cx, cy;
        bit er;
        reset_i = 1'b1;
        request(0, 0, 1'b0);
        draw_en_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_values("reset");
        reset_i  = 1'b0;
        button_i = 1'b0;

        // Basic stamp and corner clip
        @(negedge clk_i);
        request(10, 20, 1'b0);
        run_stroke(10, 20, 1'b0, 1'b0, -1);
        request(638, 478, 1'b0);
        run_stroke(638, 478, 1'b0, 1'b0, -1);

        // Abort on the sixth cell
        request(100, 50, 1'b0);
        run_stroke(100, 50, 1'b0, 1'b0, 5);

        // Out-of-range cursor, then button without draw window
        request(640, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("ignore_x_wr_en", 32'(wr_en_o), 32'd0);
            check("ignore_x_busy", 32'(busy_o), 32'd0);
        end
        request(5, 5, 1'b0);
        draw_en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("ignore_den_wr_en", 32'(wr_en_o), 32'd0);
            check("ignore_den_busy", 32'(busy_o), 32'd0);
        end

        // Erase with button held: retrigger right after the IDLE cycle following DONE
        request(0, 0, 1'b1);
        run_stroke(0, 0, 1'b1, 1'b1, -1);
        run_stroke(0, 0, 1'b1, 1'b0, -1);

        // Reset after three writes, then a fresh stroke
        request(200, 100, 1'b0);
        @(posedge clk_i); #1;
        button_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("pre_reset_wr_en", 32'(wr_en_o), 32'd1);
            check("pre_reset_addr", 32'(wr_address_o), 32'(100 * COLS + 200 + i));
            @(posedge clk_i); #1;
        end
        reset_i = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(negedge clk_i);
        reset_i = 1'b0;
        request(300, 200, 1'b0);
        run_stroke(300, 200, 1'b0, 1'b0, -1);

        // Random strokes, biased toward the clipping edges
        for (int k = 0; k < 10; k++) begin
            cx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(COLS - 4, COLS - 1))
                                             : int'($urandom_range(0, COLS - 1));
            cy = ($urandom_range(0, 2) == 0) ? int'($urandom_range(ROWS - 4, ROWS - 1))
                                             : int'($urandom_range(0, ROWS - 1));
            er = 1'($urandom_range(0, 1));
            request(cx, cy, er);
            run_stroke(cx, cy, er, 1'b0, (k % 4 == 3) ? int'($urandom_range(0, 15)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sand_brush_painter.md
# sand_brush_painter

Stamps a square brush of sand (or empty cells, when erasing) into the displayed cell buffer at the current cursor position. It sits upstream of the VRAM write port and is enabled only while the game state controller asserts its draw-enable output during the inter-frame wait window. It issues one cell write per cycle, clips at the screen edges, and aborts immediately when the window closes, so it never contends with the controller's RAM-to-VRAM copy.

## Interface
- ACTIVE_COLUMNS, 640, cells per row
- ACTIVE_ROWS, 480, rows per frame
- ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), cell address width
- DATA_WIDTH, 1, cell state width
- BRUSH_SIZE, 4, brush side length in cells (≥1)
- X_WIDTH, $clog2(ACTIVE_COLUMNS), cursor x width
- Y_WIDTH, $clog2(ACTIVE_ROWS), cursor y width

Ports:
- clk_i  input  1  clock
- reset_i  input  1  reset, asynchronous, active-high
- draw_en_i  input  1  draw window open (from controller draw_en_o)
- button_i  input  1  pen down request
- erase_i  input  1  1 = write empty cells, 0 = write sand
- cursor_x_i  input  X_WIDTH  brush top-left column
- cursor_y_i  input  Y_WIDTH  brush top-left row
- wr_address_o  output  ADDR_WIDTH  VRAM write address
- wr_data_o  output  DATA_WIDTH  VRAM write data
- wr_en_o  output  1  VRAM write strobe
- busy_o  output  1  stroke in progress
- done_o  output  1  one-cycle pulse on stroke completion

## Operation
- States: IDLE, PAINT, DONE.
- IDLE: if draw_en_i && button_i && cursor_x_i < ACTIVE_COLUMNS && cursor_y_i < ACTIVE_ROWS, latch x0, y0, and the data value. Data is {DATA_WIDTH{1'b1}} for sand and 0 for erase. Load row_base = y0*ACTIVE_COLUMNS, clear dx and dy, go to PAINT. An out-of-range cursor is ignored.
- PAINT: each cycle targets cell (x0+dx, y0+dy).
  - Address = row_base + x0 + dx.
  - wr_en_o = draw_en_i && (x0+dx < ACTIVE_COLUMNS) && (y0+dy < ACTIVE_ROWS).
  - Clipped cells still consume their cycle.
  - dx increments. When dx == BRUSH_SIZE-1: dx←0, dy++, and row_base += ACTIVE_COLUMNS.
  - The last cell (dx == dy == BRUSH_SIZE-1) → DONE.
- DONE: done_o=1 for one cycle → IDLE.
- Abort: if draw_en_i is 0 in any PAINT cycle, wr_en_o is 0 in that same cycle (combinational gate). The FSM then goes to IDLE with no done pulse.
- Arithmetic: coordinate sums use X_WIDTH+1 / Y_WIDTH+1 bits so they cannot wrap. The row_base addition must not overflow ADDR_WIDTH for in-range rows. Addresses of clipped cells are don't-care.
- Inputs cursor/erase/button are sampled only in IDLE. Changes during PAINT have no effect.
- busy_o = (state == PAINT).

## Timing
- Reset values: state IDLE, wr_en_o 0, busy_o 0, done_o 0, wr_address_o 0, wr_data_o 0.
- A request accepted at IDLE edge N produces its first write in cycle N+1.
- BRUSH_SIZE² PAINT cycles follow, then done_o in cycle N+1+BRUSH_SIZE².
- Back-to-back strokes: the earliest next acceptance is the IDLE cycle after DONE, i.e. BRUSH_SIZE²+2 cycles per stroke.
- wr_address_o and wr_data_o are driven from registers. wr_en_o is registered state gated combinationally by draw_en_i.
- Reset asserted mid-stroke forces IDLE asynchronously. wr_en_o drops immediately and no done pulse is issued.

## Test plan
- Basic stamp: BRUSH_SIZE=4, cursor (10,20), erase=0, draw_en held.
  - Writes data 1 to 12810–12813, 13450–13453, 14090–14093, 14730–14733 on consecutive cycles.
  - done_o pulses 17 cycles after acceptance.
- Corner clip: cursor (638,478).
  - wr_en_o is high only for 306558, 306559, 307198, 307199.
  - Still 16 PAINT cycles; done_o at cycle 17.
- Abort: draw_en_i drops after the 5th write.
  - wr_en_o is 0 in that cycle; state is IDLE next cycle.
  - No done_o; busy_o falls.
- Ignore cases:
  - Cursor (640,0) with button held: no writes, busy_o stays 0.
  - button_i=1 with draw_en_i=0: no activity.
- Erase and retrigger: erase=1 at (0,0) writes data 0 to 0–3, 640–643, 1280–1283, 1920–1923. With button held, the second stroke starts 18 cycles after the first acceptance.
- Reset mid-PAINT (after 3 writes): all outputs at reset values immediately. After release, a fresh request restarts from dx=dy=0.
